// File: rtl/irq_encoder_8.sv
// rtl/irq_encoder_8.sv - pending-register interrupt encoder with valid/ready grant handshake
//
// Captures eight request lines into a pending register, masks them, and
// presents one request at a time as a 3-bit code. A request's pending bit
// clears only when the consumer accepts its code.
//
// Ports:
//   clk       single clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   D         request lines, D[i] is request i
//   mask      1 = line i blocked from selection (still captured into pending)
//   ready     consumer accepts y when valid && ready
//   y         registered index of the presented request
//   valid     registered, y holds a request
//   pending   current pending register
//   overflow  sticky, a capture hit an already-pending bit
//
// Build option:
//   IRQ_ENC_ROUND_ROBIN_EN  defined: rotating priority starting below the last
//                           accepted index; undefined: fixed priority D7 > ... > D0

module irq_encoder_8 #(
    parameter bit EDGE   = 1'b1,
    parameter int NREQ   = 8,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   D,
    input  logic [NREQ-1:0]   mask,
    input  logic              ready,
    output logic [CODE_W-1:0] y,
    output logic              valid,
    output logic [NREQ-1:0]   pending,
    output logic              overflow
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NREQ-1:0]   d_q;
    logic [NREQ-1:0]   pending_q;
    logic              overflow_q;
    logic [CODE_W-1:0] y_q;
    logic [CODE_W-1:0] y_nxt;

    logic [NREQ-1:0]   cap;
    logic [NREQ-1:0]   clr;
    logic [NREQ-1:0]   eligible;
    logic [CODE_W-1:0] sel_idx;
    logic              sel_any;
    logic              accept;

`ifdef IRQ_ENC_ROUND_ROBIN_EN
    logic [CODE_W-1:0] last_q;
    logic [CODE_W-1:0] rr_idx;
`endif

    assign valid    = (state == PRESENT);
    assign accept   = valid && ready;
    assign y        = y_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

    assign cap      = EDGE ? (D & ~d_q) : D;
    assign clr      = accept ? (NREQ'(1) << y_q) : '0;
    assign eligible = pending_q & ~mask;

    // Priority selection over the eligible set.
    always_comb begin
        sel_idx = '0;
        sel_any = |eligible;
`ifdef IRQ_ENC_ROUND_ROBIN_EN
        rr_idx  = '0;
        // Scan from furthest (last itself) to nearest (last-1) so the nearest
        // eligible index below last wins; modulo-8 wrap comes from the width.
        for (int k = NREQ; k >= 1; k--) begin
            rr_idx = last_q - CODE_W'(k);
            if (eligible[rr_idx]) begin
                sel_idx = rr_idx;
            end
        end
`else
        // Ascending scan: the highest set index is written last and wins.
        for (int i = 0; i < NREQ; i++) begin
            if (eligible[i]) begin
                sel_idx = CODE_W'(i);
            end
        end
`endif
    end

    // Next-state: a presented code is held until accepted, with no preemption.
    always_comb begin
        state_nxt = state;
        y_nxt     = y_q;
        case (state)
            IDLE: begin
                if (sel_any) begin
                    y_nxt     = sel_idx;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            y_q        <= '0;
            d_q        <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            y_q        <= y_nxt;
            d_q        <= D;
            // Set dominates clear: a re-capture of the bit being accepted keeps it pending.
            pending_q  <= (pending_q & ~clr) | cap;
            overflow_q <= overflow_q | (|(cap & pending_q & ~clr));
        end
    end

`ifdef IRQ_ENC_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= CODE_W'(NREQ - 1);
        end else if (accept) begin
            last_q <= y_q;
        end
    end
`endif

endmodule

// File: doc/irq_encoder_8.md
Name: irq_encoder_8

Overview:
- Sequential front end for the 8-to-3 encoder path.
- Captures eight asynchronous-intent request lines D[7:0] into a pending register and applies a per-line mask.
- Presents the highest-priority unmasked pending request as a 3-bit code y[2:0] with a valid/ready handshake.
- Clears each request only when the consumer accepts it, so the downstream 3-bit consumer never sees multi-hot input or loses a request.

Parameters:
- EDGE, 1: 1 = capture on rising edge of D[i] (D & ~d_q); 0 = level capture (D[i] high sets pending every cycle).
- NREQ, 8: number of request lines; fixed at 8, present for readability only.
- CODE_W, 3: code width; fixed at 3 = log2(NREQ).

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- D  input  8  request lines, D[i] is request i
- mask  input  8  1 = line i blocked from selection; still captured into pending
- ready  input  1  consumer accepts y when valid && ready
- y  output  3  index of presented request, registered
- valid  output  1  y holds a request, registered
- pending  output  8  current pending register
- overflow  output  1  sticky, set when a capture hits an already-pending bit

Behaviour:
- Reset is async on rst_n low. Outputs clear to: y=0, valid=0, pending=0, overflow=0. The internal sample d_q=0 and state=IDLE. Everything held until rst_n high. Reset mid-handshake drops all pending requests silently.
- Capture term: cap = EDGE ? (D & ~d_q) : D. d_q <= D every cycle.
- Pending update every cycle: pending <= (pending & ~clr) | cap.
  - clr is one-hot of y when valid && ready, else 0.
  - Set dominates: if cap[i] and clr[i] occur in the same cycle, the bit stays 1 and overflow is not set.
- overflow <= overflow | (|(cap & pending & ~clr)). Cleared only by reset.
- eligible = pending & ~mask.
- FSM, 2 states:
  - IDLE: valid=0.
    - If |eligible, latch y = highest set index of eligible (D7 highest priority, D0 lowest), go to PRESENT.
    - Else stay in IDLE.
  - PRESENT: valid=1, y held stable, no preemption by higher-priority arrivals or mask changes.
    - valid && ready: clear that pending bit, return to IDLE.
    - ready low: stay in PRESENT indefinitely.
- Latency, fixed priority: D[i] rises before edge k → pending[i]=1 after edge k → valid=1, y=i after edge k+1. Two cycles from an idle block.
- Throughput: one grant per 2 cycles (mandatory IDLE bubble after each accept).
- Masking a bit already presented does not withdraw it; the handshake completes normally.
- All-masked or empty: stay in IDLE, valid=0, y holds its last value.
- EDGE=1: a level held high generates exactly one request; it must fall and rise again for another.

Optional Feature:
- Macro: IRQ_ENC_ROUND_ROBIN_EN.
- Defined: rotating priority.
  - Register last = index of the last accepted grant, reset value 7.
  - The IDLE selection picks the first eligible index scanning downward from last-1, wrapping 0→7, with last itself lowest priority.
  - last updates on each valid && ready.
- Undefined: fixed priority D7 > ... > D0; the last register is not built.

Test Plan:
- Reset then single edge: D=8'h08 for 1 cycle, ready=1 → valid=1, y=3 two cycles after the D edge, pending=8'h00 after accept, overflow=0.
- Priority: D=8'h41 in the same cycle, ready=1 → grants y=6 then y=0 on consecutive handshakes 2 cycles apart.
  - With IRQ_ENC_ROUND_ROBIN_EN, from reset (last=7), the order is still 6 then 0.
- Backpressure and no preemption: D=8'h01, ready=0 until y=0 is valid, then pulse D=8'h80 → y stays 0 and valid stays 1. On ready=1, y=0 is accepted, then y=7 appears 2 cycles later.
- Mask: mask=8'h80, D=8'h84 → y=2 granted, pending=8'h80 remains, valid=0. Clear mask → y=7 granted.
- Overflow and reset: D pulses 8'h10 twice, ready=0 → overflow=1, pending=8'h10. Assert rst_n=0 mid-PRESENT → valid, y, pending, overflow all 0 immediately, no clock required.
- Round robin (macro defined): hold EDGE=0, D=8'h03, ready=1 → grants alternate y=1, 0, 1, 0. Macro undefined → y=1 every grant.
